// File: rtl/io_pkg.sv
// io_pkg: shared channel state type, counter width helper and default board timing.
package io_pkg;

  typedef enum logic [1:0] {
    IDLE_LO     = 2'd0,
    HELD_DELAY  = 2'd1,
    HELD_REPEAT = 2'd2
  } ch_state_t;

  // Width of a counter that must be able to hold the value 'limit'.
  function automatic int cnt_w(input int limit);
    return $clog2(limit + 1);
  endfunction

  // 12 MHz board: ~20.8 ms debounce, ~417 ms to first repeat,
  // ~104 ms between repeats, 3 MHz SPI clock enable.
  localparam int DEF_NUM_BTN         = 4;
  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 250_000;
  localparam int DEF_REPEAT_DELAY    = 5_000_000;
  localparam int DEF_REPEAT_PERIOD   = 1_250_000;
  localparam int DEF_DIV_RATIO       = 4;

endpackage

// File: rtl/btn_channel.sv
// btn_channel: synchroniser, debouncer and auto-repeat FSM for one button.
module btn_channel
  import io_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  input  logic btn_enable,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_repeat
);

  localparam int DB_W   = cnt_w(DEBOUNCE_CYCLES);
  localparam int RP_LIM = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RP_W   = cnt_w(RP_LIM);
  localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYCLES);
  localparam logic [RP_W-1:0] RP_DELAY  = RP_W'(REPEAT_DELAY);
  localparam logic [RP_W-1:0] RP_PERIOD = RP_W'(REPEAT_PERIOD);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic [DB_W-1:0]        db_cnt;
  logic [DB_W-1:0]        db_inc;
  logic                   db_done;
  logic                   accept_press;
  logic                   accept_release;
  ch_state_t              state;
  ch_state_t              state_n;
  logic [RP_W-1:0]        rp_cnt;
  logic [RP_W-1:0]        rp_cnt_n;
  logic [RP_W-1:0]        rp_inc;
  logic                   repeat_n;

  assign s              = sync_q[SYNC_STAGES-1];
  assign db_inc         = db_cnt + DB_W'(1);
  assign db_done        = btn_enable && (s != btn_level) && (db_inc == DB_LAST);
  assign accept_press   = db_done && !btn_level;
  assign accept_release = db_done && btn_level;
  assign rp_inc         = rp_cnt + RP_W'(1);

  // Shift the raw pin through the synchroniser chain; nothing else touches btn_raw.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw};
    end
  end

  // Accept a level change only after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      db_cnt      <= '0;
      btn_level   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
    end else if (!btn_enable) begin
      // A disabled channel reads as released; drop a held level exactly once.
      db_cnt      <= '0;
      btn_level   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= btn_level;
    end else if (s == btn_level) begin
      db_cnt      <= '0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
    end else if (db_done) begin
      db_cnt      <= '0;
      btn_level   <= ~btn_level;
      btn_press   <= accept_press;
      btn_release <= accept_release;
    end else begin
      db_cnt      <= db_inc;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
    end
  end

  // Repeat FSM state register and registered repeat pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE_LO;
      rp_cnt     <= '0;
      btn_repeat <= 1'b0;
    end else begin
      state      <= state_n;
      rp_cnt     <= rp_cnt_n;
      btn_repeat <= repeat_n;
    end
  end

  // Repeat FSM next state; release or disable always wins over a due repeat.
  always_comb begin
    state_n  = state;
    rp_cnt_n = rp_cnt;
    repeat_n = 1'b0;
    if (!btn_enable || accept_release) begin
      state_n  = IDLE_LO;
      rp_cnt_n = '0;
    end else begin
      case (state)
        IDLE_LO: begin
          if (accept_press) begin
            state_n  = HELD_DELAY;
            rp_cnt_n = '0;
          end
        end
        HELD_DELAY: begin
          // With REPEAT_DELAY of 0 the counter is frozen so it can never match.
          if (REPEAT_DELAY != 0) begin
            rp_cnt_n = rp_inc;
            if (rp_inc == RP_DELAY) begin
              repeat_n = 1'b1;
              rp_cnt_n = '0;
              state_n  = HELD_REPEAT;
            end
          end
        end
        HELD_REPEAT: begin
          rp_cnt_n = rp_inc;
          if (rp_inc == RP_PERIOD) begin
            repeat_n = 1'b1;
            rp_cnt_n = '0;
          end
        end
        default: begin
          state_n  = IDLE_LO;
          rp_cnt_n = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/io_conditioner.sv
// io_conditioner: button conditioning for NUM_BTN inputs plus SPI/IMU clock-enable divider.
module io_conditioner
  import io_pkg::*;
#(
  parameter int NUM_BTN         = DEF_NUM_BTN,
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter int DIV_RATIO       = DEF_DIV_RATIO
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_BTN-1:0]         btn_raw,
  input  logic [NUM_BTN-1:0]         btn_enable,
  output logic [NUM_BTN-1:0]         btn_level,
  output logic [NUM_BTN-1:0]         btn_press,
  output logic [NUM_BTN-1:0]         btn_release,
  output logic [NUM_BTN-1:0]         btn_repeat,
  output logic                       tick,
  output logic [$clog2(DIV_RATIO):0] tick_phase
);

  localparam int PH_W = $clog2(DIV_RATIO) + 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(DIV_RATIO - 1);

  logic [PH_W-1:0] div_cnt;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    btn_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .btn_raw    (btn_raw[i]),
      .btn_enable (btn_enable[i]),
      .btn_level  (btn_level[i]),
      .btn_press  (btn_press[i]),
      .btn_release(btn_release[i]),
      .btn_repeat (btn_repeat[i])
    );
  end

  // Wrapping divider; tick is registered from the terminal count so it is
  // glitch-free, low in reset, and lands DIV_RATIO cycles after reset release.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt <= '0;
      tick    <= 1'b0;
    end else begin
      tick    <= (div_cnt == PH_LAST);
      div_cnt <= (div_cnt == PH_LAST) ? '0 : div_cnt + PH_W'(1);
    end
  end

  assign tick_phase = div_cnt;

endmodule

// File: tb/tb_io_conditioner.sv
// tb_io_conditioner: directed scenarios plus randomized stimulus, checked by a
// queue-based scoreboard fed from a behavioural model of the button rules.
module tb_io_conditioner;

  localparam int NB = 4;
  localparam int SS = 2;
  localparam int DB = 8;
  localparam int RD = 20;
  localparam int RP = 5;
  localparam int DR = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [NB-1:0] btn_raw, btn_enable;
  logic [NB-1:0] btn_level, btn_press, btn_release, btn_repeat;
  logic          tick;
  logic [2:0]    tick_phase;

  logic       raw1, en1;
  logic       level1, press1, release1, repeat1, tick1;
  logic [0:0] phase1;

  int total = 0;
  int bad   = 0;

  io_conditioner #(
    .NUM_BTN(NB), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .DIV_RATIO(DR)
  ) dut (
    .clk(clk), .reset(reset), .btn_raw(btn_raw), .btn_enable(btn_enable),
    .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release),
    .btn_repeat(btn_repeat), .tick(tick), .tick_phase(tick_phase)
  );

  io_conditioner #(
    .NUM_BTN(1), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .DIV_RATIO(1)
  ) dut1 (
    .clk(clk), .reset(reset), .btn_raw(raw1), .btn_enable(en1),
    .btn_level(level1), .btn_press(press1), .btn_release(release1),
    .btn_repeat(repeat1), .tick(tick1), .tick_phase(phase1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NB-1:0] level;
    logic [NB-1:0] press;
    logic [NB-1:0] rel;
    logic [NB-1:0] rep;
    logic          tick;
    logic [2:0]    phase;
    logic          tick1;
  } exp_t;

  exp_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, want, $time);
    end
  endtask

  // Reference model: s is the raw input delayed by SS edges; a level change is
  // accepted after DB consecutive differing samples; repeats fall at hold times
  // RD, RD+RP, RD+2RP... counted from the press; the divider is cycles-since-reset mod DR.
  logic [NB-1:0] dly_q[$];
  logic [NB-1:0] m_lvl;
  int            m_run[NB];
  int            m_hold[NB];
  int            m_cyc;

  always @(posedge clk) begin : model
    exp_t          e;
    logic [NB-1:0] s_vec;
    logic [NB-1:0] prev;
    e.press = '0;
    e.rel   = '0;
    e.rep   = '0;
    if (reset) begin
      dly_q.delete();
      for (int k = 0; k < SS; k++) dly_q.push_back('0);
      m_lvl = '0;
      m_cyc = 0;
      for (int ch = 0; ch < NB; ch++) begin
        m_run[ch]  = 0;
        m_hold[ch] = 0;
      end
      e.tick  = 1'b0;
      e.phase = '0;
      e.tick1 = 1'b0;
    end else begin
      s_vec = dly_q.pop_front();
      dly_q.push_back(btn_raw);
      prev = m_lvl;
      m_cyc++;
      for (int ch = 0; ch < NB; ch++) begin
        if (!btn_enable[ch]) begin
          e.rel[ch] = m_lvl[ch];
          m_lvl[ch] = 1'b0;
          m_run[ch] = 0;
        end else if (s_vec[ch] != m_lvl[ch]) begin
          m_run[ch]++;
          if (m_run[ch] == DB) begin
            m_run[ch]   = 0;
            m_lvl[ch]   = s_vec[ch];
            e.press[ch] = s_vec[ch];
            e.rel[ch]   = !s_vec[ch];
            m_hold[ch]  = 0;
          end
        end else begin
          m_run[ch] = 0;
        end
        if (prev[ch] && m_lvl[ch]) begin
          m_hold[ch]++;
          if (RD > 0 && m_hold[ch] >= RD && (m_hold[ch] - RD) % RP == 0) e.rep[ch] = 1'b1;
        end
      end
      e.tick  = (m_cyc % DR == 0);
      e.phase = 3'(m_cyc % DR);
      e.tick1 = 1'b1;
    end
    e.level = m_lvl;
    exp_q.push_back(e);
  end

  // Monitor: pop one expected output set per cycle and compare on the falling edge.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("sb_level",   32'(btn_level),   32'(e.level));
      chk("sb_press",   32'(btn_press),   32'(e.press));
      chk("sb_release", 32'(btn_release), 32'(e.rel));
      chk("sb_repeat",  32'(btn_repeat),  32'(e.rep));
      chk("sb_tick",    32'(tick),        32'(e.tick));
      chk("sb_phase",   32'(tick_phase),  32'(e.phase));
      chk("sb_tick_div1",  32'(tick1),  32'(e.tick1));
      chk("sb_phase_div1", 32'(phase1), 32'(0));
      chk("sb_btn_div1", 32'({level1, press1, release1, repeat1}), 32'(0));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic glitch_seen;
    int   b;
    reset      = 1'b1;
    btn_raw    = '0;
    btn_enable = '1;
    raw1       = 1'b0;
    en1        = 1'b1;
    repeat (3) cyc();

    // Divider after reset release, plus reset state of the button outputs.
    for (int i = 0; i <= 12; i++) begin
      cyc();
      if (i == 0) reset = 1'b0;
      @(negedge clk);
      if (i == 0) chk("rst_btn", 32'({btn_level, btn_press, btn_release, btn_repeat}), 32'(0));
      chk("div_tick",  32'(tick),       32'(i >= 1 && i % 4 == 0));
      chk("div_phase", 32'(tick_phase), 32'(i % 4));
      chk("div1_tick", 32'(tick1),      32'(i >= 1));
    end

    // Clean press and release on channel 0.
    for (int i = 0; i <= 27; i++) begin
      cyc();
      if (i == 0)  btn_raw[0] = 1'b1;
      if (i == 15) btn_raw[0] = 1'b0;
      @(negedge clk);
      chk("clean_press",   32'(btn_press[0]),   32'(i == 10));
      chk("clean_release", 32'(btn_release[0]), 32'(i == 25));
      chk("clean_level",   32'(btn_level[0]),   32'(i >= 10 && i < 25));
    end

    // Glitch rejection on channel 1: a 7-cycle pulse, then 3-high/2-low bounce.
    glitch_seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      cyc();
      if (i < 7)       btn_raw[1] = 1'b1;
      else if (i < 9)  btn_raw[1] = 1'b0;
      else if (i < 49) btn_raw[1] = ((i - 9) % 5) < 3;
      else             btn_raw[1] = 1'b0;
      @(negedge clk);
      glitch_seen = glitch_seen | btn_press[1] | btn_level[1];
    end
    chk("glitch_reject", 32'(glitch_seen), 32'(0));

    // Auto-repeat on channel 2, released so that release lands on a repeat slot.
    for (int i = 0; i <= 84; i++) begin
      cyc();
      if (i == 0)  btn_raw[2] = 1'b1;
      if (i == 70) btn_raw[2] = 1'b0;
      @(negedge clk);
      chk("rep_press",   32'(btn_press[2]),   32'(i == 10));
      chk("rep_repeat",  32'(btn_repeat[2]),  32'(i >= 30 && i < 80 && (i - 30) % 5 == 0));
      chk("rep_release", 32'(btn_release[2]), 32'(i == 80));
    end

    // Disable channel 3 while held, then re-enable with the button still down.
    for (int i = 0; i <= 40; i++) begin
      cyc();
      if (i == 0)  btn_raw[3] = 1'b1;
      if (i == 15) btn_enable[3] = 1'b0;
      if (i == 25) btn_enable[3] = 1'b1;
      @(negedge clk);
      chk("dis_press",   32'(btn_press[3]),   32'(i == 10 || i == 33));
      chk("dis_release", 32'(btn_release[3]), 32'(i == 16));
      chk("dis_level",   32'(btn_level[3]),   32'((i >= 10 && i < 16) || i >= 33));
      chk("dis_repeat",  32'(btn_repeat[3]),  32'(0));
    end
    btn_raw[3] = 1'b0;
    repeat (12) cyc();

    // Reset while channel 0 is in the repeat phase, button still held afterwards.
    for (int i = 0; i <= 55; i++) begin
      cyc();
      if (i == 0)  btn_raw[0] = 1'b1;
      if (i == 40) reset = 1'b1;
      if (i == 42) reset = 1'b0;
      @(negedge clk);
      chk("rst_press",  32'(btn_press[0]),  32'(i == 10 || i == 52));
      chk("rst_repeat", 32'(btn_repeat[0]), 32'(i == 30 || i == 35 || i == 40));
      if (i == 41) begin
        chk("rst_outs", 32'({btn_level, btn_press, btn_release, btn_repeat}), 32'(0));
        chk("rst_tick", 32'({tick, tick_phase}), 32'(0));
      end
    end
    btn_raw[0] = 1'b0;
    repeat (12) cyc();

    // Randomized: fast toggling (mostly glitches) then slow toggling (holds and repeats).
    for (int n = 0; n < 600; n++) begin
      cyc();
      for (int ch = 0; ch < NB; ch++)
        if ($urandom_range(0, (n < 300) ? 5 : 39) == 0) btn_raw[ch] = ~btn_raw[ch];
      if ($urandom_range(0, 59) == 0) begin
        b = $urandom_range(0, NB - 1);
        btn_enable[b] = ~btn_enable[b];
      end
      reset = ($urandom_range(0, 249) == 0);
    end

    reset      = 1'b0;
    btn_raw    = '0;
    btn_enable = '1;
    repeat (15) cyc();
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
